// File: rtl/speed_ramp_ctrl_if.sv
// rtl/speed_ramp_ctrl_if.sv - command, config and status bundle for speed_ramp_ctrl
interface speed_ramp_ctrl_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [1:0] cfg_speed;
  logic [3:0] cfg_steps;
  logic       tick;
  logic [3:0] counter_value;
  logic [1:0] stage;
  logic [1:0] cur_speed;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, pause, cfg_we, cfg_addr, cfg_speed, cfg_steps,
    input  tick, counter_value, stage, cur_speed, busy, done
  );

  modport slave (
    input  start, stop, pause, cfg_we, cfg_addr, cfg_speed, cfg_steps,
    output tick, counter_value, stage, cur_speed, busy, done
  );
endinterface

// File: rtl/speed_ramp_ctrl.sv
// rtl/speed_ramp_ctrl.sv - 4-stage speed profile sequencer driving a shared rate divider
module speed_ramp_ctrl #(
  parameter logic [10:0] DIV0 = 11'd0,
  parameter logic [10:0] DIV1 = 11'd499,
  parameter logic [10:0] DIV2 = 11'd999,
  parameter logic [10:0] DIV3 = 11'd1999,
  parameter bit          LOOP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  speed_ramp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] div_cnt;
  logic [3:0]  step_cnt;
  logic [3:0]  steps_cur;
  logic [3:0]  counter_value;
  logic [1:0]  stage;
  logic [1:0]  cur_speed;
  logic [1:0]  tbl_speed [4];
  logic [3:0]  tbl_steps [4];
  logic [1:0]  stage_inc;
  logic        tick;
  logic        last_step;
  logic        go;
  logic        finish;

  function automatic logic [10:0] div_of(input logic [1:0] sp);
    case (sp)
      2'd0:    div_of = DIV0;
      2'd1:    div_of = DIV1;
      2'd2:    div_of = DIV2;
      default: div_of = DIV3;
    endcase
  endfunction

  // steps of 0 wraps to 15 here, which yields the intended 16 ticks
  assign last_step = (step_cnt == (steps_cur - 4'd1));
  assign go        = bus.start && !bus.stop && (state == S_IDLE || state == S_DONE);
  assign finish    = tick && last_step && (stage == 2'd3) && (LOOP == 1'b0);
  assign stage_inc = stage + 2'd1;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state: stop beats start beats pause; finishing the profile beats pause
  always_comb begin
    state_nxt = state;
    if (bus.stop) begin
      state_nxt = S_IDLE;
    end else if (go) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (finish)         state_nxt = S_DONE;
          else if (bus.pause) state_nxt = S_PAUSED;
        end
        S_PAUSED: begin
          if (!bus.pause) state_nxt = S_RUN;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // state-derived outputs
  always_comb begin
    tick     = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    tick     = (state == S_RUN) && (div_cnt == 11'd0);
    bus.busy = (state == S_RUN) || (state == S_PAUSED);
    bus.done = (state == S_DONE);
  end

  // profile table; writes land on the edge regardless of state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        tbl_speed[i] <= 2'(i);
        tbl_steps[i] <= 4'd4;
      end
    end else if (bus.cfg_we) begin
      tbl_speed[bus.cfg_addr] <= bus.cfg_speed;
      tbl_steps[bus.cfg_addr] <= bus.cfg_steps;
    end
  end

  // divider, tick counter and stage sequencing; table reads see pre-write values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      step_cnt      <= '0;
      steps_cur     <= 4'd4;
      counter_value <= '0;
      stage         <= '0;
      cur_speed     <= '0;
    end else if (go) begin
      counter_value <= '0;
      step_cnt      <= '0;
      stage         <= '0;
      cur_speed     <= tbl_speed[0];
      steps_cur     <= tbl_steps[0];
      div_cnt       <= div_of(tbl_speed[0]);
    end else if (tick) begin
      counter_value <= counter_value + 4'd1;
      if (last_step) begin
        step_cnt <= '0;
        if (!finish) begin
          stage     <= stage_inc;
          cur_speed <= tbl_speed[stage_inc];
          steps_cur <= tbl_steps[stage_inc];
          div_cnt   <= div_of(tbl_speed[stage_inc]);
        end
      end else begin
        step_cnt <= step_cnt + 4'd1;
        div_cnt  <= div_of(cur_speed);
      end
    end else if (state == S_RUN) begin
      div_cnt <= div_cnt - 11'd1;
    end
  end

  assign bus.tick          = tick;
  assign bus.counter_value = counter_value;
  assign bus.stage         = stage;
  assign bus.cur_speed     = cur_speed;

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// tb/tb_speed_ramp_ctrl.sv - randomized scoreboard bench for speed_ramp_ctrl
module tb_speed_ramp_ctrl;

  typedef struct {
    int t;
    int cv;
    int st;
    int sp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;
  int   dv [4] = '{0, 1, 2, 3};
  int   m_sp [4];
  int   m_st [4];
  exp_t sbq [$];
  exp_t mon_e;

  speed_ramp_ctrl_if ifc ();
  speed_ramp_ctrl_if lif ();

  speed_ramp_ctrl #(
    .DIV0(11'd0), .DIV1(11'd1), .DIV2(11'd2), .DIV3(11'd3), .LOOP(1'b0)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  speed_ramp_ctrl #(
    .DIV0(11'd0), .DIV1(11'd1), .DIV2(11'd2), .DIV3(11'd3), .LOOP(1'b1)
  ) u_loop (
    .clk(clk),
    .rst(rst),
    .bus(lif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every tick the DUT presents is matched against the next expected tick
  always @(negedge clk) begin
    if (!rst && chk_en && ifc.tick) begin
      if (sbq.size() == 0) begin
        check("unexpected_tick_cycle", cyc, -1);
      end else begin
        mon_e = sbq.pop_front();
        check("tick_cycle", cyc, mon_e.t);
        check("tick_count", int'(ifc.counter_value), mon_e.cv);
        check("tick_stage", int'(ifc.stage), mon_e.st);
        check("tick_speed", int'(ifc.cur_speed), mon_e.sp);
      end
    end
  end

  task automatic set_default_table();
    for (int i = 0; i < 4; i++) begin
      m_sp[i] = i;
      m_st[i] = 4;
    end
  endtask

  task automatic write_cfg(input int a, input int sp, input int st);
    @(negedge clk);
    ifc.cfg_we    = 1'b1;
    ifc.cfg_addr  = 2'(a);
    ifc.cfg_speed = 2'(sp);
    ifc.cfg_steps = 4'(st);
    m_sp[a] = sp;
    m_st[a] = st;
    @(negedge clk);
    ifc.cfg_we = 1'b0;
  endtask

  // Reference: each tick lands DIV+1 cycles after the previous one (or after the
  // Start cycle), using the speed of the stage it belongs to; ticks after the pause
  // onset slip by the pause length, and ticks after a stop never happen.
  task automatic run_scenario(input bit do_pause, input bit do_stop, input bit wr_at_start);
    int s, p, l, q, t, tt, k, stg_after, n, sp, sp0, st0, nsp, nst;
    bit cut;
    @(negedge clk);
    s   = cyc;
    p   = do_pause ? s + int'($urandom_range(2, 60)) : -1;
    l   = do_pause ? int'($urandom_range(1, 12)) : 0;
    q   = do_stop ? s + int'($urandom_range(2, 150)) : -1;
    nsp = int'($urandom_range(0, 3));
    nst = int'($urandom_range(0, 15));
    sp0 = m_sp[0];
    st0 = m_st[0];
    t = s; k = 0; stg_after = 0; cut = 1'b0;
    for (int st = 0; st < 4 && !cut; st++) begin
      sp = (st == 0) ? sp0 : m_sp[st];
      n  = (st == 0) ? st0 : m_st[st];
      if (n == 0) n = 16;
      for (int j = 0; j < n && !cut; j++) begin
        t  = t + dv[sp] + 1;
        tt = (p >= 0 && t > p) ? t + l : t;
        if (q >= 0 && tt > q) begin
          cut = 1'b1;
        end else begin
          sbq.push_back('{tt, k % 16, st, sp});
          k++;
          stg_after = (j == n - 1 && st < 3) ? st + 1 : st;
        end
      end
    end
    if (wr_at_start) begin
      m_sp[0] = nsp;
      m_st[0] = nst;
    end
    for (int c = s; c < s + 300; c++) begin
      ifc.start     = (c == s);
      ifc.pause     = (p >= 0 && c >= p && c < p + l);
      ifc.stop      = (c == q);
      ifc.cfg_we    = wr_at_start && (c == s);
      ifc.cfg_addr  = 2'd0;
      ifc.cfg_speed = 2'(nsp);
      ifc.cfg_steps = 4'(nst);
      @(negedge clk);
    end
    check("end_count", int'(ifc.counter_value), k % 16);
    check("end_stage", int'(ifc.stage), stg_after);
    check("end_done", int'(ifc.done), (!cut && q < 0) ? 1 : 0);
    check("end_busy", int'(ifc.busy), 0);
    check("missed_ticks", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, int'(ifc.tick), 0);
    check({tag, "_count"}, int'(ifc.counter_value), 0);
    check({tag, "_stage"}, int'(ifc.stage), 0);
    check({tag, "_speed"}, int'(ifc.cur_speed), 0);
    check({tag, "_busy"}, int'(ifc.busy), 0);
    check({tag, "_done"}, int'(ifc.done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected end by 1000000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.pause = 1'b0; ifc.cfg_we = 1'b0;
    ifc.cfg_addr = 2'd0; ifc.cfg_speed = 2'd0; ifc.cfg_steps = 4'd0;
    lif.start = 1'b0; lif.stop = 1'b0; lif.pause = 1'b0; lif.cfg_we = 1'b0;
    lif.cfg_addr = 2'd0; lif.cfg_speed = 2'd0; lif.cfg_steps = 4'd0;
    set_default_table();
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    chk_en = 1'b1;
    run_scenario(1'b0, 1'b0, 1'b0);

    write_cfg(0, 0, 0);
    run_scenario(1'b0, 1'b0, 1'b0);

    write_cfg(0, 3, 4);
    run_scenario(1'b1, 1'b0, 1'b0);

    run_scenario(1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 4; i++)
        write_cfg(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      run_scenario(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lif.cfg_we = 1'b1; lif.cfg_addr = 2'(i); lif.cfg_speed = 2'd0; lif.cfg_steps = 4'd1;
    end
    @(negedge clk);
    lif.cfg_we = 1'b0;
    lif.start  = 1'b1;
    @(negedge clk);
    lif.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("loop_tick", int'(lif.tick), 1);
      check("loop_stage", int'(lif.stage), i % 4);
      check("loop_count", int'(lif.counter_value), i % 16);
      check("loop_done", int'(lif.done), 0);
      @(negedge clk);
    end
    lif.stop = 1'b1;
    @(negedge clk);
    lif.stop = 1'b0;

    chk_en = 1'b0;
    write_cfg(0, 3, 1);
    write_cfg(2, 0, 9);
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_busy", int'(ifc.busy), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    set_default_table();
    chk_en = 1'b1;
    run_scenario(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
